// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions: digit type, digit limits and the legal-code test.
package bcd_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    function automatic logic bcd_legal(input bcd_digit_t nibble);
        return nibble <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: load with clamping, single up/down step, self-repair of illegal codes.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  bcd_digit_t ld_digit,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t digit,
    output logic       at_max,
    output logic       at_min,
    output logic       load_clamped
);
    bcd_digit_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_legal(ld_digit) ? ld_digit : BCD_MAX;
        end else if (en && !bcd_legal(digit_q)) begin
            // Upset recovery: the chain never sees this digit as 9 or 0, so no carry leaks out.
            digit_d = BCD_ZERO;
        end else if (step) begin
            if (up) digit_d = (digit_q == BCD_MAX)  ? BCD_ZERO : digit_q + 4'd1;
            else    digit_d = (digit_q == BCD_ZERO) ? BCD_MAX  : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) digit_q <= BCD_ZERO;
        else     digit_q <= digit_d;
    end

    assign digit        = digit_q;
    assign at_max       = (digit_q == BCD_MAX);
    assign at_min       = (digit_q == BCD_ZERO);
    assign load_clamped = load && !bcd_legal(ld_digit);
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with parallel load, wrap or saturate at the ends,
// combinational terminal count for cascading, and registered overflow / load-error pulses.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);
    logic [DIGITS-1:0] at_max, at_min, load_clamped;
    logic [DIGITS-1:0] carry, borrow, step;
    logic              blocked;
    logic              ovf_q, ovf_d, load_err_q, load_err_d;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .load         (load),
            .ld_digit     (load_val[BCD_W*k +: BCD_W]),
            .step         (step[k]),
            .up           (up),
            .digit        (bcd[BCD_W*k +: BCD_W]),
            .at_max       (at_max[k]),
            .at_min       (at_min[k]),
            .load_clamped (load_clamped[k])
        );
    end

    assign tc = en && (up ? &at_max : &at_min);

    always_comb begin
        carry     = '0;
        borrow    = '0;
        carry[0]  = en && up;
        borrow[0] = en && !up;
        for (int k = 1; k < DIGITS; k++) begin
            carry[k]  = carry[k-1]  && at_max[k-1];
            borrow[k] = borrow[k-1] && at_min[k-1];
        end
        // In saturating mode the step that would cross an end is swallowed, but still flagged.
        blocked = !WRAP && tc;
        step    = (up ? carry : borrow) & {DIGITS{!blocked}};
        ovf_d      = tc && !load;
        load_err_d = load && |load_clamped;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign ovf      = ovf_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: wrapping and saturating instances driven in parallel
// by directed and random stimulus, checked against an integer-valued reference model.
module tb_bcd_updown_counter;
    localparam int MAXV = 99;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] bcd_w, bcd_s;
    logic       tc_w, tc_s, ovf_w, ovf_s, lerr_w, lerr_s;

    int  n_chk = 0, n_err = 0;
    int  mw = 0, ms = 0;
    bit  ow, os, le;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd_w), .tc(tc_w), .ovf(ovf_w), .load_err(lerr_w)
    );

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd_s), .tc(tc_s), .ovf(ovf_s), .load_err(lerr_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int min9(input logic [3:0] n);
        return (n > 4'd9) ? 9 : int'(n);
    endfunction

    task automatic model_next(input bit r, input bit e, input bit u, input bit l,
                              input logic [7:0] lv, input bit wrap,
                              inout int v, output bit o);
        o = 1'b0;
        if (r) v = 0;
        else if (l) v = min9(lv[7:4]) * 10 + min9(lv[3:0]);
        else if (e) begin
            if (u) begin
                if (v == MAXV) begin o = 1'b1; v = wrap ? 0 : MAXV; end
                else v = v + 1;
            end else begin
                if (v == 0) begin o = 1'b1; v = wrap ? MAXV : 0; end
                else v = v - 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit u, input bit l, input logic [7:0] lv);
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_val = lv;
        #1;
        chk("tc_wrap", tc_w, e && (u ? mw == MAXV : mw == 0));
        chk("tc_sat",  tc_s, e && (u ? ms == MAXV : ms == 0));
        model_next(r, e, u, l, lv, 1'b1, mw, ow);
        model_next(r, e, u, l, lv, 1'b0, ms, os);
        le = !r && l && (lv[7:4] > 4'd9 || lv[3:0] > 4'd9);
        @(posedge clk);
        #1;
        chk("bcd_wrap",  bcd_w,  to_bcd(mw));
        chk("ovf_wrap",  ovf_w,  ow);
        chk("lerr_wrap", lerr_w, le);
        chk("bcd_sat",   bcd_s,  to_bcd(ms));
        chk("ovf_sat",   ovf_s,  os);
        chk("lerr_sat",  lerr_s, le);
    endtask

    initial begin
        logic [7:0] edge_vals [4];
        edge_vals[0] = 8'h99; edge_vals[1] = 8'h00; edge_vals[2] = 8'h98; edge_vals[3] = 8'h01;

        // Reset, second reset cycle with en=1/up=0 expects tc=1, then count up 11 steps
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 11; i++) cyc(0, 1, 1, 0, 8'h00);

        // Up through the top
        cyc(0, 0, 0, 1, 8'h98);
        cyc(0, 1, 1, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);

        // Down through zero
        cyc(0, 0, 0, 1, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);

        // Clamped loads
        cyc(0, 1, 1, 1, 8'h3C);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'hF5);
        cyc(0, 0, 0, 0, 8'h00);

        // Reset coincident with load while counting
        cyc(0, 0, 0, 1, 8'h47);
        cyc(0, 1, 1, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'h55);
        cyc(0, 1, 1, 0, 8'h00);

        // Direction change and hold
        cyc(0, 0, 0, 1, 8'h50);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);

        // Random traffic biased toward the end values
        for (int i = 0; i < 400; i++) begin
            bit r, e, u, l;
            logic [7:0] lv;
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 9) < 7);
            u  = $urandom_range(0, 1) != 0;
            lv = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 3)] : 8'($urandom);
            cyc(r, e, u, l, lv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
